// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction memory
// and holds the core in reset until a length- and checksum-verified image is resident.
module imem_loader #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   input  logic        reload,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   output logic        load_done,
   output logic        load_err
);

   typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state, state_nxt;
   logic [15:0] count;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [7:0]  csum;
   logic [23:0] word_buf;

   logic        xfer;
   logic [16:0] len_full;
   logic        last_word;
   logic        word_end;

   assign xfer      = byte_valid && byte_ready;
   assign len_full  = {1'b0, byte_data, count[7:0]};
   assign last_word = (word_idx == count - 16'd1);
   assign word_end  = xfer && (state == DATA) && (byte_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) state <= LEN0;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LEN0: if (xfer) state_nxt = LEN1;
         LEN1: begin
            if (xfer) begin
               if (len_full > DEPTH_W)     state_nxt = ERR;
               else if (len_full == 17'd0) state_nxt = CSUM;
               else                        state_nxt = DATA;
            end
         end
         DATA: if (word_end && last_word) state_nxt = CSUM;
         CSUM: if (xfer) state_nxt = (byte_data == csum) ? DONE : ERR;
         DONE, ERR: if (reload) state_nxt = LEN0;
         default: state_nxt = LEN0;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      case (state)
         LEN0, LEN1, DATA, CSUM: byte_ready = 1'b1;
         default:                byte_ready = 1'b0;
      endcase
   end

   // Control and write-port stage: indices, status flags and the one-cycle write strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx   <= 2'd0;
         word_idx   <= 16'd0;
         imem_we    <= 1'b0;
         imem_addr  <= 32'd0;
         imem_wdata <= 32'd0;
         core_rst   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         imem_we   <= 1'b0;
         core_rst  <= (state_nxt != DONE);
         load_done <= (state_nxt == DONE);
         load_err  <= (state_nxt == ERR);
         if (xfer && state == DATA) byte_idx <= byte_idx + 2'd1;
         if (word_end) begin
            imem_we    <= 1'b1;
            imem_wdata <= {byte_data, word_buf};
            imem_addr  <= {14'd0, word_idx, 2'b00};
            word_idx   <= word_idx + 16'd1;
         end
         if ((state == DONE || state == ERR) && reload) begin
            byte_idx <= 2'd0;
            word_idx <= 16'd0;
         end
      end
   end

   // Byte capture stage: length, running checksum and the three low word lanes
   always_ff @(posedge clk) begin
      if (xfer) begin
         case (state)
            LEN0: begin
               count[7:0] <= byte_data;
               csum       <= byte_data;
            end
            LEN1: begin
               count[15:8] <= byte_data;
               csum        <= csum ^ byte_data;
            end
            DATA: begin
               csum <= csum ^ byte_data;
               case (byte_idx)
                  2'd0:    word_buf[7:0]   <= byte_data;
                  2'd1:    word_buf[15:8]  <= byte_data;
                  2'd2:    word_buf[23:16] <= byte_data;
                  default: word_buf        <= word_buf;
               endcase
            end
            default: csum <= csum;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares each imem_we pulse.
module tb_imem_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        reload;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        load_done;
   logic        load_err;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  stim[$];
   logic [63:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("write_addr", imem_addr, mon_e[63:32]);
            chk("write_data", imem_wdata, mon_e[31:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends stim[] one byte per cycle; checks imem_we is high exactly after each word's 4th byte.
   task automatic send_stream(input int nwords, input int gap_after, input int gap_len, input int reload_at);
      for (int i = 0; i < stim.size(); i++) begin
         byte_valid = 1'b1;
         byte_data  = stim[i];
         reload     = (i == reload_at);
         chk("byte_ready", {31'd0, byte_ready}, 32'd1);
         tick();
         byte_valid = 1'b0;
         reload     = 1'b0;
         chk("we_timing", {31'd0, imem_we},
             {31'd0, (i >= 2 && i < 2 + 4 * nwords && ((i - 2) % 4) == 3)});
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               tick();
               chk("we_gap", {31'd0, imem_we}, 32'd0);
            end
         end
      end
   endtask

   task automatic chk_status(input string name, input logic c, input logic d, input logic e, input logic r);
      chk({name, "_core_rst"},  {31'd0, core_rst},   {31'd0, c});
      chk({name, "_load_done"}, {31'd0, load_done},  {31'd0, d});
      chk({name, "_load_err"},  {31'd0, load_err},   {31'd0, e});
      chk({name, "_byte_ready"}, {31'd0, byte_ready}, {31'd0, r});
   endtask

   task automatic chk_reset_state(input string name);
      chk_status(name, 1'b1, 1'b0, 1'b0, 1'b1);
      chk({name, "_we"},    {31'd0, imem_we}, 32'd0);
      chk({name, "_addr"},  imem_addr,        32'd0);
      chk({name, "_wdata"}, imem_wdata,       32'd0);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk_status("reload", 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic basic_load(input logic [7:0] last);
      stim = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h8C};
      stim.push_back(last);
      exp_q.push_back({32'h0000_0000, 32'h2008_0005});
      exp_q.push_back({32'h0000_0004, 32'h8C09_0004});
      send_stream(2, -1, 0, -1);
   endtask

   initial begin
      logic [7:0]  cs;
      logic [31:0] w;
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      reload     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_reset_state("reset");

      // Basic load
      basic_load(8'hAE);
      chk_status("basic_done", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("basic_queue", exp_q.size(), 32'd0);

      // Bad checksum
      do_reload();
      basic_load(8'hAF);
      chk_status("badcsum", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("badcsum_queue", exp_q.size(), 32'd0);

      // Empty image
      do_reload();
      stim = '{8'h00, 8'h00, 8'h00};
      send_stream(0, -1, 0, -1);
      chk_status("empty_done", 1'b0, 1'b1, 1'b0, 1'b0);

      // Over-length: N = DEPTH+1, further byte_valid ignored
      do_reload();
      stim = '{8'h01, 8'h01};
      send_stream(0, -1, 0, -1);
      chk_status("overlen", 1'b1, 1'b0, 1'b1, 1'b0);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      tick();
      tick();
      byte_valid = 1'b0;
      chk_status("overlen_hold", 1'b1, 1'b0, 1'b1, 1'b0);

      // Stalls between bytes 5 and 6, then rst after byte 8
      do_reload();
      stim = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00};
      exp_q.push_back({32'h0000_0000, 32'h2008_0005});
      send_stream(2, 4, 3, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_state("midrst");
      chk("midrst_queue", exp_q.size(), 32'd0);
      basic_load(8'hAE);
      chk_status("midrst_done", 1'b0, 1'b1, 1'b0, 1'b0);

      // Reload with a reload pulse during DATA that must be ignored
      do_reload();
      stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
      exp_q.push_back({32'h0000_0000, 32'h0000_0013});
      send_stream(1, -1, 0, 3);
      chk_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("reload_queue", exp_q.size(), 32'd0);

      // N = DEPTH is legal
      do_reload();
      stim = '{8'h00, 8'h01};
      cs   = 8'h01;
      for (int k = 0; k < DEPTH; k++) begin
         w = {8'(k) ^ 8'h5A, 8'(k), 8'hC3, 8'(k)};
         for (int b = 0; b < 4; b++) begin
            stim.push_back(w[8*b +: 8]);
            cs = cs ^ w[8*b +: 8];
         end
         exp_q.push_back({32'(k * 4), w});
      end
      stim.push_back(cs);
      send_stream(DEPTH, -1, 0, -1);
      chk_status("full_done", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("full_queue", exp_q.size(), 32'd0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader upstream of the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written through the instruction memory write port, and the loader holds the core in reset until a complete, checksum-verified image is resident. The core then fetches from PC = 0 on the first cycle after release.

## Interface
- `DEPTH`, 256: instruction memory capacity in words; maximum legal word count.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `byte_valid` in 1: `byte_data` holds a valid byte.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: single-cycle request to restart loading; honoured only in DONE/ERR.
- `imem_we` out 1: instruction memory write enable, one-cycle pulse per word.
- `imem_addr` out 32: byte address of the word being written, always word-aligned (word k at 4*k).
- `imem_wdata` out 32: instruction word.
- `core_rst` out 1: reset to PC and register file; high while no verified image is present.
- `load_done` out 1: image loaded and verified.
- `load_err` out 1: length or checksum failure.

## Operation
- Stream format:
  - 2-byte word count N, low byte first.
  - 4*N data bytes, each word least-significant byte first.
  - 1 checksum byte equal to the XOR of every preceding byte, including both length bytes.
- FSM states: LEN0, LEN1, DATA, CSUM, DONE, ERR. Reset state is LEN0.
- LEN0:
  - Accept the byte into count[7:0].
  - Clear the checksum accumulator to the accepted byte.
  - Go to LEN1.
- LEN1:
  - Accept the byte into count[15:8].
  - If the full count > DEPTH, go to ERR.
  - Else if count == 0, go to CSUM.
  - Else go to DATA.
- DATA:
  - Shift each byte into the word assembler at lane byte_idx (0..3).
  - On the 4th byte, register a write: `imem_wdata` = assembled word, `imem_addr` = {word_idx, 2'b00}, `imem_we` = 1 for exactly the next cycle.
  - Increment word_idx and clear byte_idx.
  - After word N-1, go to CSUM.
- CSUM:
  - Accept one byte.
  - If it equals the accumulator, go to DONE; otherwise go to ERR.
- DONE: `load_done` = 1, `core_rst` = 0.
- ERR: `load_err` = 1, `core_rst` = 1. Words already written are not erased.
- `reload` in DONE/ERR:
  - Return to LEN0.
  - Set `core_rst` = 1 and clear `load_done`, `load_err`, word_idx, byte_idx.
  - `reload` has no effect in any other state.
- The checksum accumulator XORs every accepted byte from LEN0 through the last data byte.
- word_idx is 16-bit. N = DEPTH is legal; N = DEPTH+1 errors without writing anything.

## Timing
- Reset values:
  - `core_rst` = 1.
  - `imem_we` = 0.
  - `imem_addr` = 0, `imem_wdata` = 0.
  - `load_done` = 0, `load_err` = 0.
  - FSM = LEN0, byte_idx = 0, word_idx = 0.
- `byte_ready` is a combinational decode: 1 in LEN0, LEN1, DATA and CSUM; 0 in DONE and ERR. It is not gated by `byte_valid`.
- A transfer occurs on the rising edge where `byte_valid` && `byte_ready`. Throughput is one byte per cycle; gaps in `byte_valid` stall the FSM with no state change.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are valid in the cycle immediately after the edge accepting a word's 4th byte. Back-to-back words give a write every 4 cycles.
- `core_rst`, `load_done` and `load_err` are registered and change on the edge that enters DONE, ERR or LEN0. `core_rst` falls on the same edge `load_done` rises.
- `rst` overrides everything, including a mid-DATA load or a pending `imem_we`: all outputs return to reset values on the next edge.
- `rst` and `reload` together: `rst` wins.

## Test plan
- Basic load:
  - Stimulus: N=2, bytes 02 00 05 00 08 20 04 00 09 8C AE.
  - Response: writes (addr 0x0, 0x20080005) and (addr 0x4, 0x8C090004), each a one-cycle `imem_we` pulse the cycle after the 4th byte. DONE follows, `core_rst` falls, `load_done` = 1, `byte_ready` = 0.
- Bad checksum:
  - Stimulus: same stream with final byte AF.
  - Response: both writes still occur. `load_err` = 1, `core_rst` stays 1, `load_done` = 0.
- Empty image:
  - Stimulus: bytes 00 00 00.
  - Response: no `imem_we`, DONE after 3 bytes.
- Over-length:
  - Stimulus: 01 01 (N=257, DEPTH=256).
  - Response: ERR after the second byte, no writes, `byte_ready` = 0; a further `byte_valid` is ignored.
- Stalls and mid-load reset:
  - Stimulus: basic load with `byte_valid` low for 3 cycles between bytes 5 and 6, then `rst` asserted after byte 8.
  - Response: no spurious writes during the gap. After `rst`, FSM is in LEN0 with all outputs at reset values, and the basic load then completes correctly.
- Reload:
  - Stimulus: from DONE pulse `reload`, then send N=1, 01 00 13 00 00 00 12.
  - Response: `core_rst` rises on the next edge. Write (0x0, 0x00000013), then DONE. A `reload` pulse during DATA is ignored.
